// File: rtl/clk_switch_pkg.sv
// Shared state encoding, output bundle and parameter limits for the CPU
// fast/host clock switch controller.
package clk_switch_pkg;

  localparam int CNT_W          = 4;
  localparam int GUARD_CYC_DEF  = 2;
  localparam int GUARD_CYC_MIN  = 0;
  localparam int GUARD_CYC_MAX  = 15;
  localparam int SLOW_EDGES_DEF = 1;
  localparam int SLOW_EDGES_MIN = 1;
  localparam int SLOW_EDGES_MAX = 15;

  typedef enum logic [2:0] {
    FAST      = 3'd0,
    ARM       = 3'd1,
    GUARD_IN  = 3'd2,
    SLOW      = 3'd3,
    GUARD_OUT = 3'd4,
    DONE      = 3'd5
  } state_e;

  typedef struct packed {
    logic edge_en;
    logic hold;
    logic gate;
    logic sel_slow;
    logic slow_ack;
  } ctrl_t;

  // Moore decode: every control output is a pure function of the state.
  function automatic ctrl_t decode_ctrl(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      ARM:       begin c.edge_en = 1'b1; c.hold = 1'b1; end
      GUARD_IN:  begin c.hold = 1'b1; c.gate = 1'b1; c.sel_slow = 1'b1; end
      SLOW:      begin c.edge_en = 1'b1; c.sel_slow = 1'b1; end
      GUARD_OUT: begin c.hold = 1'b1; c.gate = 1'b1; end
      DONE:      c.slow_ack = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/down_cnt.sv
// 4-bit loadable down counter with zero flag; saturates at zero, never wraps.
module down_cnt
  import clk_switch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_switch_fsm.sv
// Sequences the CPU clock mux between the fast clock and the host phase,
// with gated guard intervals around each select change.
module clk_switch_fsm
  import clk_switch_pkg::*;
#(
  parameter int GUARD_CYC  = GUARD_CYC_DEF,   // 0..15
  parameter int SLOW_EDGES = SLOW_EDGES_DEF   // 1..15
) (
  input  logic clk,
  input  logic rst_b,
  input  logic edge_det,
  input  logic slow_req,
  output logic edge_en,
  output logic hold,
  output logic gate,
  output logic sel_slow,
  output logic slow_ack
);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             run_q;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [CNT_W-1:0] cnt_load_val, cnt_val;

  down_cnt u_cnt (
    .clk        (clk),
    .rst_b      (rst_b),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Zero also terminates so a counter that somehow reached zero cannot stall.
  assign cnt_last = (cnt_val == CNT_W'(1)) || cnt_zero;

  // run_q holds the FSM idle for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= FAST;
      ctrl_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      run_q   <= 1'b1;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FAST:      if (run_q && slow_req) state_d = ARM;
      ARM: begin
        if (!slow_req)    state_d = FAST;
        else if (edge_det) state_d = (GUARD_CYC == 0) ? SLOW : GUARD_IN;
      end
      GUARD_IN:  if (cnt_last) state_d = SLOW;
      SLOW:      if (edge_det && cnt_last) state_d = (GUARD_CYC == 0) ? DONE : GUARD_OUT;
      GUARD_OUT: if (cnt_last) state_d = DONE;
      DONE:      state_d = FAST;
      default:   state_d = FAST;
    endcase
  end

  always_comb begin
    cnt_load     = (state_d != state_q) &&
                   ((state_d == GUARD_IN) || (state_d == SLOW) || (state_d == GUARD_OUT));
    cnt_load_val = (state_d == SLOW) ? CNT_W'(SLOW_EDGES) : CNT_W'(GUARD_CYC);
    cnt_dec      = (state_q == GUARD_IN) || (state_q == GUARD_OUT) ||
                   ((state_q == SLOW) && edge_det);
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    ctrl_d = decode_ctrl(state_d);
  end

  assign edge_en  = ctrl_q.edge_en;
  assign hold     = ctrl_q.hold;
  assign gate     = ctrl_q.gate;
  assign sel_slow = ctrl_q.sel_slow;
  assign slow_ack = ctrl_q.slow_ack;

endmodule
